// File: rtl/fetch_if.sv
//------------------------------------------------------------------------------
// fetch_if : instruction-memory read bus between fetch and memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        imem_err;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data, imem_err);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data, imem_err);
endinterface

`default_nettype wire

// File: rtl/fetch.sv
//------------------------------------------------------------------------------
// fetch : prefetching instruction fetch with a 2-entry queue and redirect drop.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_exec_stall,
  input  wire logic        i_mem_stall,
  input  wire logic        i_jump_valid,
  input  wire logic [31:0] i_jump_addr,
  input  wire logic        i_exc_valid,
  input  wire logic [31:0] i_exc_addr,
  output logic      [31:0] o_pc,
  output logic      [31:0] o_instr,
  output logic             o_fetch_stall,
  output logic             o_fetch_error,
  fetch_if.master          imem
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DROP  = 1'b1
  } state_t;

  localparam logic [31:0] c_nop = 32'h0000_0000;

  state_t            r_state;
  logic              r_req;
  logic [31:0]       r_addr;
  logic [31:0]       r_target;
  logic [1:0]        r_count;
  logic [1:0][31:0]  r_pc;
  logic [1:0][31:0]  r_instr;
  logic [1:0]        r_err;

  logic        w_has;
  logic        w_consume;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_ack;
  logic        w_push;
  logic [1:0]  w_count_pop;
  logic [1:0]  w_count_next;
  logic        w_room;
  logic [31:0] w_addr_inc;

  assign w_has        = (r_count != 2'd0);
  assign w_consume    = w_has && !i_exec_stall && !i_mem_stall;
  assign w_redirect   = i_exc_valid || i_jump_valid;
  assign w_target     = {(i_exc_valid ? i_exc_addr[31:2] : i_jump_addr[31:2]), 2'b00};
  assign w_ack        = r_req && imem.imem_ack;
  assign w_push       = w_ack && (r_state == S_FETCH) && !w_redirect;
  assign w_count_pop  = r_count - {1'b0, w_consume};
  assign w_count_next = w_redirect ? 2'd0 : (w_count_pop + {1'b0, w_push});
  assign w_room       = !w_count_next[1];
  assign w_addr_inc   = r_addr + 32'd4;

  // Queue: entry 0 is the head; a pop shifts entry 1 down before the push lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_pc    <= '0;
      r_instr <= '0;
      r_err   <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_consume) begin
        r_pc[0]    <= r_pc[1];
        r_instr[0] <= r_instr[1];
        r_err[0]   <= r_err[1];
      end
      if (w_push) begin
        r_pc[w_count_pop[0]]    <= r_addr;
        r_instr[w_count_pop[0]] <= imem.imem_err ? c_nop : imem.imem_data;
        r_err[w_count_pop[0]]   <= imem.imem_err;
      end
    end
  end

  // r_addr doubles as the next fetch address while no request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_target <= RESET_PC;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_redirect && r_req && !w_ack) begin
            r_state  <= S_DROP;
            r_target <= w_target;
          end else if (w_redirect) begin
            r_req  <= 1'b1;
            r_addr <= w_target;
          end else if (w_ack) begin
            r_req  <= w_room;
            r_addr <= w_addr_inc;
          end else if (!r_req) begin
            r_req <= w_room;
          end
        end
        S_DROP: begin
          if (w_ack) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= w_redirect ? w_target : r_target;
          end else if (w_redirect) begin
            r_target <= w_target;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign o_pc          = w_has ? r_pc[0]    : 32'h0;
  assign o_instr       = w_has ? r_instr[0] : c_nop;
  assign o_fetch_error = w_has && r_err[0];
  assign o_fetch_stall = !w_has;

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
//------------------------------------------------------------------------------
// tb_fetch : directed self-checking bench for fetch with a simple memory model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_stall, mem_stall;
  logic        jump_valid, exc_valid;
  logic [31:0] jump_addr, exc_addr;
  logic [31:0] pc, instr;
  logic        fstall, ferr;

  int unsigned mem_delay = 0;
  int unsigned wait_cnt  = 0;
  logic        err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;
  logic        saw_jump  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fetch_if bus ();

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_exec_stall  (exec_stall),
    .i_mem_stall   (mem_stall),
    .i_jump_valid  (jump_valid),
    .i_jump_addr   (jump_addr),
    .i_exc_valid   (exc_valid),
    .i_exc_addr    (exc_addr),
    .o_pc          (pc),
    .o_instr       (instr),
    .o_fetch_stall (fstall),
    .o_fetch_error (ferr),
    .imem          (bus)
  );

  always #5 clk = ~clk;

  // Memory returns the address as data after mem_delay wait cycles.
  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                                      wait_cnt <= wait_cnt + 1;
    if (bus.imem_req && bus.imem_ack && bus.imem_addr == 32'h200) saw_jump <= 1'b1;
  end

  assign bus.imem_ack  = bus.imem_req && (wait_cnt == mem_delay);
  assign bus.imem_data = bus.imem_addr;
  assign bus.imem_err  = err_en && (bus.imem_addr == err_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; exec_stall = 1'b0; mem_stall = 1'b0;
    jump_valid = 1'b0; exc_valid = 1'b0; jump_addr = '0; exc_addr = '0;
    repeat (2) @(negedge clk);

    check("rst_stall", fstall, 1);
    check("rst_instr", instr, 0);
    check("rst_pc", pc, 0);
    check("rst_err", ferr, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 32'h0);

    // Zero-wait streaming
    rst = 1'b0;
    tick;
    check("first_req", bus.imem_req, 1);
    check("first_addr", bus.imem_addr, 32'h0);
    check("first_stall", fstall, 1);
    tick;
    check("seq_pc0", pc, 32'h0);
    check("seq_instr0", instr, 32'h0);
    check("seq_stall_low", fstall, 0);
    for (int i = 1; i <= 5; i++) begin
      tick;
      check("seq_pc", pc, 32'(4 * i));
      check("seq_instr", instr, 32'(4 * i));
    end

    // Execute stall: queue fills, bus stops, head frozen
    exec_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("xstall_pc", pc, 32'd20);
      check("xstall_instr", instr, 32'd20);
      check("xstall_req", bus.imem_req, 0);
      check("xstall_addr", bus.imem_addr, 32'd28);
    end
    exec_stall = 1'b0;
    tick; check("resume_pc24", pc, 32'd24);
    tick; check("resume_pc28", pc, 32'd28);
    tick; check("resume_pc32", pc, 32'd32);
    mem_stall = 1'b1;
    tick; check("mstall_pc", pc, 32'd32);
    mem_stall = 1'b0;
    tick; check("mstall_resume", pc, 32'd36);

    // Bus error at 0x40
    err_en = 1'b1; err_addr = 32'h40;
    n = 0;
    while (pc != 32'h40 && n < 16) begin
      tick;
      n++;
    end
    check("err_pc", pc, 32'h40);
    check("err_instr", instr, 32'h0);
    check("err_flag", ferr, 1);
    tick;
    check("after_err_pc", pc, 32'h44);
    check("after_err_instr", instr, 32'h44);
    check("after_err_flag", ferr, 0);
    err_en = 1'b0;

    // Redirect while a slow request is in flight
    mem_delay = 3;
    tick;
    jump_valid = 1'b1; jump_addr = 32'h100;
    tick;
    jump_valid = 1'b0;
    check("drop_stall", fstall, 1);
    check("drop_req", bus.imem_req, 1);
    check("drop_addr_hold", bus.imem_addr, 32'h48);
    tick;
    check("drop_ack_addr", bus.imem_addr, 32'h48);
    tick;
    check("drop_new_addr", bus.imem_addr, 32'h100);
    check("drop_discard", fstall, 1);
    mem_delay = 0;
    tick;
    check("drop_pc", pc, 32'h100);
    check("drop_instr", instr, 32'h100);

    // Exception beats jump in the same cycle
    jump_valid = 1'b1; jump_addr = 32'h200;
    exc_valid  = 1'b1; exc_addr  = 32'h80;
    tick;
    jump_valid = 1'b0; exc_valid = 1'b0;
    check("exc_addr", bus.imem_addr, 32'h80);
    check("exc_flush", fstall, 1);
    tick; check("exc_pc", pc, 32'h80);
    tick; check("exc_pc_next", pc, 32'h84);

    // Misaligned redirect and address wrap
    jump_valid = 1'b1; jump_addr = 32'hFFFF_FFFE;
    tick;
    jump_valid = 1'b0;
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_next_addr", bus.imem_addr, 32'h0);
    tick;
    check("wrap_pc0", pc, 32'h0);

    // Redirect with nothing outstanding
    exec_stall = 1'b1;
    tick; tick;
    check("idle_req", bus.imem_req, 0);
    jump_valid = 1'b1; jump_addr = 32'h300;
    tick;
    jump_valid = 1'b0;
    check("idle_redir_addr", bus.imem_addr, 32'h300);
    check("idle_redir_req", bus.imem_req, 1);
    check("idle_redir_stall", fstall, 1);
    exec_stall = 1'b0;
    tick;
    check("idle_redir_pc", pc, 32'h300);

    check("jump_never_fetched", saw_jump, 0);

    // Reset mid-request abandons it
    mem_delay = 5;
    tick; tick;
    rst = 1'b1;
    #1;
    check("midrst_req", bus.imem_req, 0);
    check("midrst_addr", bus.imem_addr, 32'h0);
    check("midrst_stall", fstall, 1);
    tick;
    check("midrst_hold_req", bus.imem_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
